// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store bridge: FSM states, access sizes,
// byte-enable seeds and the default bus timeout.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and replicated store data on the
// way out, lane extraction plus sign/zero extension on the way back.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  lsu_size_e         size,
    input  logic [1:0]        offset,
    input  logic              load_unsigned,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [WIDTH-1:0]  rdata,
    output logic [3:0]        be,
    output logic [WIDTH-1:0]  wdata_rep,
    output logic [WIDTH-1:0]  load_data
);

    logic [WIDTH-1:0] lane;

    always_comb begin
        lane      = rdata >> {offset, 3'b000};
        be        = BE_WORD;
        wdata_rep = wdata;
        load_data = rdata;
        case (size)
            SZ_BYTE: begin
                be        = BE_BYTE << offset;
                wdata_rep = {4{wdata[7:0]}};
                load_data = {{(WIDTH-8){~load_unsigned & lane[7]}}, lane[7:0]};
            end
            SZ_HALF: begin
                // Halfwords only ever sit in lane 0 or lane 2
                be        = BE_HALF << {offset[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                load_data = {{(WIDTH-16){~load_unsigned & lane[15]}}, lane[15:0]};
            end
            default: begin
                be        = BE_WORD;
                wdata_rep = wdata;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge: one core memory op -> one word-aligned bus transfer.
// Define LSU_TIMEOUT_EN to abort a transfer whose ack never arrives.
module lsu_mem_bridge
    import lsu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              is_byte,
    input  logic              is_half,
    input  logic              is_word,
    input  logic              load_unsigned,
    input  logic [WIDTH-1:0]  addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic              lsu_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [WIDTH-1:0]  bus_addr,
    output logic [3:0]        bus_be,
    output logic [WIDTH-1:0]  bus_wdata,
    input  logic              bus_ack,
    input  logic [WIDTH-1:0]  bus_rdata
);

    lsu_state_e       state, state_nxt;
    lsu_size_e        size_dec, size_q;
    logic [WIDTH-1:0] addr_q, wdata_q;
    logic             uns_q, we_q, err_q;
    logic             accept, req_err, timeout_hit;
    logic [3:0]       be;
    logic [WIDTH-1:0] wdata_rep, load_data;

    assign accept = (state == ST_IDLE) && (mem_read || mem_write);

    // Byte wins over half, half over word; no flag at all is a fault
    always_comb begin
        size_dec = SZ_WORD;
        req_err  = 1'b0;
        if (is_byte) begin
            size_dec = SZ_BYTE;
        end else if (is_half) begin
            size_dec = SZ_HALF;
            req_err  = addr[0];
        end else if (is_word) begin
            req_err  = |addr[1:0];
        end else begin
            req_err  = 1'b1;
        end
        if (mem_read && mem_write) req_err = 1'b1;
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             wait_cnt <= '0;
        else if (accept)                        wait_cnt <= '0;
        else if (state == ST_BUS && !bus_ack)   wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout_hit = (state == ST_BUS) && !bus_ack && (wait_cnt == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = req_err ? ST_RESP : ST_BUS;
            ST_BUS:  if (bus_ack || timeout_hit) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata   <= '0;
        end else if (accept) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            size_q  <= size_dec;
            uns_q   <= load_unsigned;
            we_q    <= mem_write;
            err_q   <= req_err;
        end else if (state == ST_BUS) begin
            if (bus_ack) begin
                if (!we_q) rdata <= load_data;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    lsu_lane_align #(.WIDTH(WIDTH)) u_align (
        .size          (size_q),
        .offset        (addr_q[1:0]),
        .load_unsigned (uns_q),
        .wdata         (wdata_q),
        .rdata         (bus_rdata),
        .be            (be),
        .wdata_rep     (wdata_rep),
        .load_data     (load_data)
    );

    // Bus fields are gated so the idle bus is quiet and reset drives all zeros
    assign bus_req   = (state == ST_BUS);
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = bus_req ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    assign bus_be    = bus_req ? be : 4'b0000;
    assign bus_wdata = bus_req ? wdata_rep : '0;

    assign lsu_busy  = (state == ST_BUS) || (state == ST_RESP);
    assign lsu_done  = (state == ST_RESP);
    assign lsu_err   = (state == ST_RESP) && err_q;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge; timeout case runs when LSU_TIMEOUT_EN is defined.
module tb_lsu_mem_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic        is_byte = 1'b0, is_half = 1'b0, is_word = 1'b0, load_unsigned = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        lsu_busy, lsu_done, lsu_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int n_chk = 0;
    int n_fail = 0;

    // captured per transaction
    int          req_cycles, done_cycle;
    logic        err_seen, stable;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    always #5 clk = ~clk;

    lsu_mem_bridge #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .is_byte(is_byte), .is_half(is_half), .is_word(is_word),
        .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata), .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_err(lsu_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge with the unit idle; returns #1 after the accept edge.
    task automatic start_op(input logic rd, input logic wr, input logic b, input logic h,
                            input logic w, input logic u, input logic [31:0] a,
                            input logic [31:0] wd);
        mem_read = rd; mem_write = wr; is_byte = b; is_half = h; is_word = w;
        load_unsigned = u; addr = a; wdata = wd;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
    endtask

    // Serves the bus: ack after 'waits' request cycles. Cycle 0 is the accept cycle.
    task automatic run_bus(input int waits, input logic [31:0] word);
        req_cycles = 0; done_cycle = -1; err_seen = 1'b0; stable = 1'b1;
        cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
        bus_rdata = word;
        for (int c = 1; c <= 40; c++) begin
            bus_ack = bus_req && (req_cycles == waits);
            @(negedge clk);
            if (bus_req) begin
                if (req_cycles == 0) begin
                    cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_we = bus_we;
                end else if (bus_addr !== cap_addr || bus_be !== cap_be ||
                             bus_wdata !== cap_wdata || bus_we !== cap_we) begin
                    stable = 1'b0;
                end
                req_cycles++;
            end
            if (lsu_done) begin
                done_cycle = c; err_seen = lsu_err;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            if (done_cycle != -1) break;
        end
        if (done_cycle == -1) chk("done_timeout", 32'(done_cycle), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ctrl", {28'h0, lsu_busy, lsu_done, lsu_err, bus_req}, 32'h0);
        chk("rst_bus", {bus_addr ^ bus_wdata, 3'b000, bus_we, bus_be}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // LB 0x103, signed, zero-wait
        start_op(1, 0, 1, 0, 0, 0, 32'h0000_0103, 32'h0);
        run_bus(0, 32'h80FF_1234);
        chk("lb_addr", cap_addr, 32'h0000_0100);
        chk("lb_be", {28'h0, cap_be}, 32'h8);
        chk("lb_we", {31'h0, cap_we}, 32'h0);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        chk("lb_lat", 32'(done_cycle), 32'd2);
        chk("lb_err", {31'h0, err_seen}, 32'h0);

        // SH 0x202, back-to-back with the previous op
        start_op(0, 1, 0, 1, 0, 0, 32'h0000_0202, 32'h0000_BEEF);
        run_bus(0, 32'hDEAD_0000);
        chk("sh_we", {31'h0, cap_we}, 32'h1);
        chk("sh_addr", cap_addr, 32'h0000_0200);
        chk("sh_be", {28'h0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        chk("sh_rdata_kept", rdata, 32'hFFFF_FF80);

        // LHU 0x006 with three wait cycles
        start_op(1, 0, 0, 1, 0, 1, 32'h0000_0006, 32'h0);
        run_bus(3, 32'hA5A5_0000);
        chk("lhu_rdata", rdata, 32'h0000_A5A5);
        chk("lhu_req_cycles", 32'(req_cycles), 32'd4);
        chk("lhu_lat", 32'(done_cycle), 32'd5);
        chk("lhu_addr", cap_addr, 32'h0000_0004);
        chk("lhu_stable", {31'h0, stable}, 32'h1);

        // LH signed lane 0, LBU lane 1
        start_op(1, 0, 0, 1, 0, 0, 32'h0000_0000, 32'h0);
        run_bus(1, 32'h1234_8001);
        chk("lh_rdata", rdata, 32'hFFFF_8001);
        start_op(1, 0, 1, 0, 0, 1, 32'h0000_0001, 32'h0);
        run_bus(0, 32'h0000_9A00);
        chk("lbu_rdata", rdata, 32'h0000_009A);

        // SB 0x001 and SW 0x008: byte wins when several size flags are set
        start_op(0, 1, 1, 1, 1, 0, 32'h0000_0001, 32'h1234_56AB);
        run_bus(0, 32'h0);
        chk("sb_be", {28'h0, cap_be}, 32'h2);
        chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
        start_op(0, 1, 0, 0, 1, 0, 32'h0000_0008, 32'hCAFE_F00D);
        run_bus(0, 32'h0);
        chk("sw_be", {28'h0, cap_be}, 32'hF);
        chk("sw_wdata", cap_wdata, 32'hCAFE_F00D);
        chk("sw_rdata_kept", rdata, 32'h0000_009A);

        // Faults: misaligned word, no size, read+write together
        start_op(1, 0, 0, 0, 1, 0, 32'h0000_0101, 32'h0);
        run_bus(0, 32'h7777_7777);
        chk("lw_mis_req", 32'(req_cycles), 32'd0);
        chk("lw_mis_lat", 32'(done_cycle), 32'd1);
        chk("lw_mis_err", {31'h0, err_seen}, 32'h1);
        chk("lw_mis_rdata", rdata, 32'h0000_009A);
        start_op(1, 0, 0, 0, 0, 0, 32'h0000_0010, 32'h0);
        run_bus(0, 32'h7777_7777);
        chk("nosize_err", {31'h0, err_seen}, 32'h1);
        start_op(1, 1, 0, 0, 1, 0, 32'h0000_0010, 32'h0);
        run_bus(0, 32'h7777_7777);
        chk("rdwr_err", {31'h0, err_seen}, 32'h1);
        chk("rdwr_req", 32'(req_cycles), 32'd0);

        // Reset while waiting on the bus
        start_op(1, 0, 0, 0, 1, 0, 32'h0000_0010, 32'h0);
        @(negedge clk);
        chk("rstmid_req_before", {31'h0, bus_req}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rstmid_ctrl", {29'h0, bus_req, lsu_busy, lsu_done}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        start_op(1, 0, 0, 0, 1, 0, 32'h0000_0010, 32'h0);
        run_bus(0, 32'h1234_5678);
        chk("rstmid_lw_rdata", rdata, 32'h1234_5678);
        chk("rstmid_lw_addr", cap_addr, 32'h0000_0010);

`ifdef LSU_TIMEOUT_EN
        // Ack never comes: TIMEOUT=4 request cycles, then a faulted done
        start_op(1, 0, 0, 0, 1, 0, 32'h0000_0020, 32'h0);
        run_bus(1000, 32'hBAD0_BAD0);
        chk("to_req_cycles", 32'(req_cycles), 32'd4);
        chk("to_lat", 32'(done_cycle), 32'd5);
        chk("to_err", {31'h0, err_seen}, 32'h1);
        chk("to_rdata_kept", rdata, 32'h1234_5678);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
